// File: rtl/march_pkg.sv
// Shared types and March C- element tables for the SRAM BIST pattern generator.
// Elements M0..M5 follow March C-; DONE is the terminal state.
package march_pkg;

   typedef enum logic [2:0] {
      M0   = 3'd0,
      M1   = 3'd1,
      M2   = 3'd2,
      M3   = 3'd3,
      M4   = 3'd4,
      M5   = 3'd5,
      DONE = 3'd6
   } march_elem_t;

   localparam int BG_MAX_W = 64;

   function automatic logic elem_is_down(input march_elem_t e);
      return (e == M3) || (e == M4);
   endfunction

   function automatic logic [1:0] elem_num_ops(input march_elem_t e);
      case (e)
         M1, M2, M3, M4: return 2'd2;
         default:        return 2'd1;
      endcase
   endfunction

   function automatic logic elem_op_is_write(input march_elem_t e, input logic op);
      case (e)
         M0:             return 1'b1;
         M1, M2, M3, M4: return op;
         default:        return 1'b0;
      endcase
   endfunction

   // 1 selects the inverted background for this op.
   function automatic logic elem_op_polarity(input march_elem_t e, input logic op);
      case (e)
         M1, M3:  return op;
         M2, M4:  return ~op;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic bg_bit(input logic [1:0] k, input logic [2:0] i);
      case (k)
         2'd0:    return 1'b0;
         2'd1:    return i[0];
         2'd2:    return i[1];
         default: return i[2];
      endcase
   endfunction

   function automatic logic [BG_MAX_W-1:0] background(input logic [1:0] k);
      logic [BG_MAX_W-1:0] b;
      for (int i = 0; i < BG_MAX_W; i++) b[i] = bg_bit(k, 3'(i));
      return b;
   endfunction

endpackage

// File: rtl/march_cm_patgen_if.sv
// BIST request bus between the March C- pattern generator and its consumer.
interface march_cm_patgen_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 4
);
   logic                  en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data;
   logic [DATA_WIDTH-1:0] expected;
   logic [MASK_WIDTH-1:0] wmask;
   logic                  we;
   logic                  re;
   logic                  done;
   logic [2:0]            elem;
   logic [1:0]            bg_idx;

   modport master (input en, output addr, data, expected, wmask, we, re, done, elem, bg_idx);
   modport slave  (output en, input addr, data, expected, wmask, we, re, done, elem, bg_idx);
endinterface

// File: rtl/march_addr_counter.sv
// Loadable up/down address counter; last_o flags the final address of the current direction.
module march_addr_counter #(
   parameter int ADDR_WIDTH = 8,
   parameter int MAX_ADDR   = 2**ADDR_WIDTH-1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  step_i,
   input  logic                  load_i,
   input  logic                  load_down_i,
   input  logic                  down_i,
   output logic [ADDR_WIDTH-1:0] cnt_o,
   output logic                  last_o
);
   localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(MAX_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)      cnt_d = load_down_i ? MAX_A : '0;
      else if (step_i) cnt_d = down_i ? (cnt_q - ONE) : (cnt_q + ONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign last_o = down_i ? (cnt_q == '0) : (cnt_q == MAX_A);
endmodule

// File: rtl/march_cm_patgen.sv
// March C- BIST pattern generator: sweeps the address space once per data background.
// All bus outputs decode directly from registered state.
module march_cm_patgen
   import march_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 4,
   parameter int MAX_ADDR   = 2**ADDR_WIDTH-1,
   parameter int NUM_BG     = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   march_cm_patgen_if.master      bus
);
   localparam logic [1:0] LAST_BG = 2'(NUM_BG-1);

   march_elem_t           elem_q, elem_d;
   logic                  op_q, op_d;
   logic [1:0]            bg_q, bg_d;
   logic                  step, load, load_down, last_addr, last_op;
   logic                  is_wr, pol;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] bg_word;

   march_addr_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MAX_ADDR   (MAX_ADDR)
   ) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .step_i      (step),
      .load_i      (load),
      .load_down_i (load_down),
      .down_i      (elem_is_down(elem_q)),
      .cnt_o       (cnt),
      .last_o      (last_addr)
   );

   always_comb begin
      elem_d    = elem_q;
      op_d      = op_q;
      bg_d      = bg_q;
      step      = 1'b0;
      load      = 1'b0;
      load_down = 1'b0;
      last_op   = (elem_num_ops(elem_q) == 2'd1) || op_q;
      if (bus.en && (elem_q != DONE)) begin
         if (!last_op) begin
            op_d = 1'b1;
         end else begin
            op_d = 1'b0;
            if (!last_addr) begin
               step = 1'b1;
            end else if (elem_q != M5) begin
               elem_d    = march_elem_t'(elem_q + 3'd1);
               load      = 1'b1;
               load_down = elem_is_down(elem_d);
            end else if (bg_q < LAST_BG) begin
               // Next background restarts at M0 from address 0.
               bg_d   = bg_q + 2'd1;
               elem_d = M0;
               load   = 1'b1;
            end else begin
               elem_d = DONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         elem_q <= M0;
         op_q   <= 1'b0;
         bg_q   <= 2'd0;
      end else begin
         elem_q <= elem_d;
         op_q   <= op_d;
         bg_q   <= bg_d;
      end
   end

   always_comb begin
      bg_word = '0;
      for (int i = 0; i < DATA_WIDTH; i++) bg_word[i] = bg_bit(bg_q, 3'(i));
   end

   assign is_wr        = elem_op_is_write(elem_q, op_q);
   assign pol          = elem_op_polarity(elem_q, op_q);
   assign bus.addr     = cnt;
   assign bus.data     = pol ? ~bg_word : bg_word;
   assign bus.expected = pol ? ~bg_word : bg_word;
   assign bus.wmask    = '1;
   assign bus.we       = (elem_q != DONE) && is_wr;
   assign bus.re       = (elem_q != DONE) && !is_wr;
   assign bus.done     = (elem_q == DONE);
   assign bus.elem     = elem_q;
   assign bus.bg_idx   = bg_q;
endmodule

// File: tb/tb_march_cm_patgen.sv
// Bench for march_cm_patgen: two configurations driven with stalls and resets,
// compared every cycle against an op list built from the March C- element table.
module tb_march_cm_patgen;

   typedef struct {
      int addr;
      bit we;
      bit re;
      int val;
      int elem;
      int bg;
   } op_t;
   typedef op_t op_q_t[$];

   logic  clk = 1'b0;
   logic  rst;
   int    checks = 0;
   int    errors = 0;
   int    ia = 0;
   int    ib = 0;
   op_q_t qa, qb;

   always #5 clk = ~clk;

   march_cm_patgen_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .MASK_WIDTH(4)) bus_a ();
   march_cm_patgen_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .MASK_WIDTH(4)) bus_b ();

   march_cm_patgen #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .MASK_WIDTH(4), .MAX_ADDR(3), .NUM_BG(2))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
   march_cm_patgen #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .MASK_WIDTH(4), .MAX_ADDR(0), .NUM_BG(1))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

   function automatic int bg_value(int k, int dw);
      int v = 0;
      for (int i = 0; i < dw; i++)
         if (k > 0 && ((i >> (k - 1)) & 1) == 1) v = v | (1 << i);
      return v;
   endfunction

   // Full op list for one run: elements x backgrounds x addresses x ops.
   function automatic op_q_t build(int max_a, int nbg, int dw);
      op_q_t q;
      op_t   t;
      int    nops [6]    = '{1, 2, 2, 2, 2, 1};
      bit    down [6]    = '{0, 0, 0, 1, 1, 0};
      bit    isw  [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
      bit    inv  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
      int    mask = (1 << dw) - 1;
      for (int b = 0; b < nbg; b++)
         for (int e = 0; e < 6; e++)
            for (int s = 0; s <= max_a; s++)
               for (int o = 0; o < nops[e]; o++) begin
                  t.addr = down[e] ? (max_a - s) : s;
                  t.we   = isw[e][o];
                  t.re   = !isw[e][o];
                  t.val  = inv[e][o] ? (~bg_value(b, dw) & mask) : bg_value(b, dw);
                  t.elem = e;
                  t.bg   = b;
                  q.push_back(t);
               end
      return q;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_vals(input string nm, input op_q_t q, input int idx, input int nbg,
                             input logic [31:0] addr, input logic [31:0] we, input logic [31:0] re,
                             input logic [31:0] data, input logic [31:0] expd, input logic [31:0] done,
                             input logic [31:0] elem, input logic [31:0] bg, input logic [31:0] wmask);
      op_t  e;
      logic fin;
      fin = (idx >= q.size());
      if (!fin) begin
         e = q[idx];
      end else begin
         e      = q[q.size() - 1];
         e.we   = 1'b0;
         e.re   = 1'b0;
         e.elem = 6;
         e.bg   = nbg - 1;
      end
      chk({nm, ".addr"},  addr,  32'(e.addr));
      chk({nm, ".we"},    we,    32'(e.we));
      chk({nm, ".re"},    re,    32'(e.re));
      chk({nm, ".done"},  done,  32'(fin));
      chk({nm, ".elem"},  elem,  32'(e.elem));
      chk({nm, ".bg"},    bg,    32'(e.bg));
      chk({nm, ".wmask"}, wmask, 32'hF);
      if (!fin) begin
         chk({nm, ".data"},     data, 32'(e.val));
         chk({nm, ".expected"}, expd, 32'(e.val));
      end
   endtask

   task automatic check_both();
      check_vals("a", qa, ia, 2, 32'(bus_a.addr), 32'(bus_a.we), 32'(bus_a.re), 32'(bus_a.data),
                 32'(bus_a.expected), 32'(bus_a.done), 32'(bus_a.elem), 32'(bus_a.bg_idx), 32'(bus_a.wmask));
      check_vals("b", qb, ib, 1, 32'(bus_b.addr), 32'(bus_b.we), 32'(bus_b.re), 32'(bus_b.data),
                 32'(bus_b.expected), 32'(bus_b.done), 32'(bus_b.elem), 32'(bus_b.bg_idx), 32'(bus_b.wmask));
   endtask

   // mode 0: random en, 1: en pattern 1,0,0,1, 2: en held high. Entered and left at a negedge.
   task automatic run(input int mode, input int stop_a, input int stop_b);
      int cyc = 0;
      while (!(ia >= stop_a && ib >= stop_b) && cyc < 3000) begin
         check_both();
         case (mode)
            0: begin
               bus_a.en = ($urandom_range(3) != 0);
               bus_b.en = 1'($urandom_range(1));
            end
            1: begin
               bus_a.en = ((cyc % 4) == 0) || ((cyc % 4) == 3);
               bus_b.en = bus_a.en;
            end
            default: begin
               bus_a.en = 1'b1;
               bus_b.en = 1'b1;
            end
         endcase
         @(posedge clk);
         if (bus_a.en) ia++;
         if (bus_b.en) ib++;
         cyc++;
         @(negedge clk);
      end
      bus_a.en = 1'b0;
      bus_b.en = 1'b0;
      chk("run_bound", 32'(ia >= stop_a && ib >= stop_b), 32'd1);
   endtask

   initial begin
      rst      = 1'b1;
      bus_a.en = 1'b0;
      bus_b.en = 1'b0;
      qa = build(3, 2, 8);
      qb = build(0, 1, 8);
      repeat (2) @(negedge clk);
      check_both();
      rst = 1'b0;

      // Full run with the stall pattern, past done to confirm it is terminal.
      run(1, qa.size() + 4, qb.size() + 4);

      rst = 1'b1;
      ia  = 0;
      ib  = 0;
      @(negedge clk);
      check_both();
      rst = 1'b0;

      // Advance into M2 of background 0, then reset between clock edges.
      run(2, 15, 0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      ia = 0;
      ib = 0;
      check_both();
      @(negedge clk);
      rst = 1'b0;

      run(0, qa.size() + 4, qb.size() + 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
